// File: rtl/nf_reg_file_pkg.sv
// nanoFOX register file shared types.
// Sweep FSM state and address width helper.
package nf_reg_file_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_t;

  function automatic int rf_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/nf_rf_rd_port.sv
// nanoFOX register file read port.
// Resolves clear, zero-register and write-bypass priority.
module nf_rf_rd_port
  import nf_reg_file_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic [AW-1:0]   ra,
  input  logic [XLEN-1:0] word,
  input  rf_state_t       state,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd
);

  logic zero_hit;
  logic wr_drop;
  logic byp_hit;

  assign zero_hit = ZERO_R0 && (ra == '0);
  assign wr_drop  = ZERO_R0 && (wa == '0);
  assign byp_hit  = BYPASS && we && !wr_drop && (wa == ra);

  always_comb begin
    rd = word;
    if (state == RF_CLEAR) begin
      rd = '0;
    end else if (zero_hit) begin
      rd = '0;
    end else if (byp_hit) begin
      rd = wd;
    end
  end

endmodule

// File: rtl/nf_reg_file_mp.sv
// nanoFOX multi-port register file.
// Post-reset clear sweep, NRP async read ports, one write port.
module nf_reg_file_mp
  import nf_reg_file_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 32,
  parameter int NRP     = 3,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1,
  localparam int AW     = rf_aw(DEPTH)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NRP*AW-1:0]   ra,
  output logic [NRP*XLEN-1:0] rd,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                we,
  output logic                ready
);

  logic [XLEN-1:0] mem [DEPTH];

  rf_state_t       state;
  rf_state_t       state_n;
  logic [AW-1:0]   clr_cnt;
  logic [AW-1:0]   clr_cnt_n;

  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= RF_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    if (state == RF_CLEAR) begin
      clr_cnt_n = clr_cnt + 1'b1;
      if (clr_cnt == AW'(DEPTH - 1)) begin
        state_n = RF_READY;
      end
    end
  end

  assign ready = (state == RF_READY);

  // Sweep owns the write port until ready; user writes are dropped.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = wa;
    mem_wd = wd;
    if (resetn) begin
      if (state == RF_CLEAR) begin
        mem_we = 1'b1;
        mem_wa = clr_cnt;
        mem_wd = '0;
      end else if (we && !(ZERO_R0 && (wa == '0))) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rp
    nf_rf_rd_port #(
      .XLEN    (XLEN),
      .AW      (AW),
      .ZERO_R0 (ZERO_R0),
      .BYPASS  (BYPASS)
    ) u_rd_port (
      .ra    (ra[i*AW +: AW]),
      .word  (mem[ra[i*AW +: AW]]),
      .state (state),
      .we    (we),
      .wa    (wa),
      .wd    (wd),
      .rd    (rd[i*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_nf_reg_file_mp.sv
// Directed bench for nf_reg_file_mp.
// Instance a: defaults; instance b: ZERO_R0=0, BYPASS=0.
module tb_nf_reg_file_mp;

  logic        clk;
  logic        resetn;
  logic [14:0] ra;
  logic [95:0] rd_a;
  logic [95:0] rd_b;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        we;
  logic        ready_a;
  logic        ready_b;

  int n_vec;
  int n_miss;

  nf_reg_file_mp u_dut_a (
    .clk    (clk),
    .resetn (resetn),
    .ra     (ra),
    .rd     (rd_a),
    .wa     (wa),
    .wd     (wd),
    .we     (we),
    .ready  (ready_a)
  );

  nf_reg_file_mp #(
    .ZERO_R0 (1'b0),
    .BYPASS  (1'b0)
  ) u_dut_b (
    .clk    (clk),
    .resetn (resetn),
    .ra     (ra),
    .rd     (rd_b),
    .wa     (wa),
    .wd     (wd),
    .we     (we),
    .ready  (ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int a2, input int a1, input int a0);
    ra = {5'(a2), 5'(a1), 5'(a0)};
    #1;
  endtask

  task automatic sweep_wait(input string tag);
    for (int i = 0; i < 32; i++) begin
      check({tag, "_rdy_lo"}, 32'(ready_a), 32'd0);
      if (i == 1) begin
        we = 1'b1;
        wa = 5'd3;
        wd = 32'h55;
        set_ra(3, 3, 3);
        check({tag, "_rd_clr"}, rd_a[31:0], 32'h0);
      end else begin
        we = 1'b0;
      end
      tick();
    end
    we = 1'b0;
    check({tag, "_rdy_a"}, 32'(ready_a), 32'd1);
    check({tag, "_rdy_b"}, 32'(ready_b), 32'd1);
  endtask

  task automatic all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      set_ra(a, a, a);
      check({tag, "_a"}, rd_a[31:0], 32'h0);
      check({tag, "_b"}, rd_b[31:0], 32'h0);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    resetn = 1'b0;
    we     = 1'b0;
    wa     = '0;
    wd     = '0;
    ra     = '0;

    for (int i = 0; i < 3; i++) tick();
    set_ra(3, 2, 1);
    check("rst_ready", 32'(ready_a), 32'd0);
    check("rst_rd0", rd_a[31:0], 32'h0);
    check("rst_rd2", rd_a[95:64], 32'h0);
    resetn = 1'b1;

    sweep_wait("sweep1");
    all_zero("clr1");
    set_ra(0, 0, 3);
    check("sweep_wr_drop", rd_a[31:0], 32'h0);

    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    set_ra(5, 5, 5);
    check("wr_rd0", rd_a[31:0], 32'hDEADBEEF);
    check("wr_rd1", rd_a[63:32], 32'hDEADBEEF);
    check("wr_rd2", rd_a[95:64], 32'hDEADBEEF);

    we = 1'b1; wa = 5'd0; wd = 32'h12345678;
    set_ra(0, 0, 0);
    check("zero_byp_a", rd_a[31:0], 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("zero_a", rd_a[31:0], 32'h0);
    check("zero_b", rd_b[31:0], 32'h12345678);

    we = 1'b1; wa = 5'd7; wd = 32'h1;
    tick();
    wd = 32'hAA;
    set_ra(0, 7, 7);
    check("byp_a_rd1", rd_a[63:32], 32'hAA);
    check("byp_a_rd0", rd_a[31:0], 32'hAA);
    check("nobyp_b_rd1", rd_b[63:32], 32'h1);
    check("byp_a_rd2_r0", rd_a[95:64], 32'h0);
    tick();
    we = 1'b0;
    #1;
    check("post_b_rd1", rd_b[63:32], 32'hAA);
    check("post_a_rd1", rd_a[63:32], 32'hAA);

    for (int i = 1; i < 32; i++) begin
      we = 1'b1;
      wa = 5'(i);
      wd = 32'hA5000000 | 32'(i);
      tick();
    end
    we = 1'b0;
    set_ra(31, 1, 17);
    check("fill_a17", rd_a[31:0], 32'hA5000011);
    check("fill_b1", rd_b[63:32], 32'hA5000001);
    check("fill_a31", rd_a[95:64], 32'hA500001F);

    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    check("mid_rdy_lo", 32'(ready_a), 32'd0);
    check("mid_rd_a", rd_a[31:0], 32'h0);
    check("mid_rd_b", rd_b[63:32], 32'h0);
    for (int i = 0; i < 10; i++) tick();
    check("cnt10_rdy", 32'(ready_a), 32'd0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    sweep_wait("sweep2");
    all_zero("clr2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
